// File: rtl/mc_exec_pkg.sv
// Shared opcode/funct constants and enums for the multicycle execute core.
package mc_exec_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT} alu_op_t;

endpackage

// File: rtl/mc_exec_regfile.sv
// Register file with two operand reads, a debug read and two prioritised write ports.
// Port A (core writeback) beats port B (external) when both target the same register; R0 is hardwired to zero.
module mc_exec_regfile #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     i_rdAddrA,
  input  logic [AW-1:0]     i_rdAddrB,
  input  logic [AW-1:0]     i_dbgAddr,
  output logic [DATA_W-1:0] o_rdDataA,
  output logic [DATA_W-1:0] o_rdDataB,
  output logic [DATA_W-1:0] o_dbgData,
  input  logic              i_weA,
  input  logic [AW-1:0]     i_waddrA,
  input  logic [DATA_W-1:0] i_wdataA,
  input  logic              i_weB,
  input  logic [AW-1:0]     i_waddrB,
  input  logic [DATA_W-1:0] i_wdataB
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  // Entry 0 is cleared by reset and never written, so it always reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (i_weA && (i_waddrA == AW'(i))) r_regs[i] <= i_wdataA;
        else if (i_weB && (i_waddrB == AW'(i))) r_regs[i] <= i_wdataB;
      end
    end
  end

  assign o_rdDataA = r_regs[i_rdAddrA];
  assign o_rdDataB = r_regs[i_rdAddrB];
  assign o_dbgData = r_regs[i_dbgAddr];

endmodule

// File: rtl/mc_exec_core.sv
// Multicycle execute core: IDLE->DECODE->EXEC->WB sequencing, ALU, branch/jump resolution.
// Optional macro MC_EXEC_OVF_TRAP_EN adds a trap output that suppresses writeback on signed overflow.
module mc_exec_core
  import mc_exec_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              ext_we,
  input  logic [4:0]        ext_addr,
  input  logic [DATA_W-1:0] ext_data,
  output logic              ext_ack,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              done,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero,
  output logic              branch_taken,
  output logic [DATA_W-1:0] next_pc,
`ifdef MC_EXEC_OVF_TRAP_EN
  output logic              trap,
`endif
  output logic              illegal
);

  localparam int AW = $clog2(NUM_REGS);
  localparam logic [AW-1:0] LINK_IDX = AW'(LINK_REG);
  localparam logic [5:0] NUM_REGS6 = 6'(NUM_REGS);

  state_t r_state, w_nextState;
  logic [31:0]       r_ir;
  logic [DATA_W-1:0] r_pc, r_a, r_b, r_aluOut, r_nextPc;
  logic              r_zero, r_branchTaken, r_illegal;

  logic [5:0]        w_op, w_funct;
  logic [AW-1:0]     w_rs, w_rt, w_rd, w_dest;
  logic [DATA_W-1:0] w_simm, w_rdA, w_rdB, w_dbgData;
  logic [DATA_W-1:0] w_srcA, w_srcB, w_aluRes, w_pcPlus4, w_nextPcCalc;
  alu_op_t           w_aluOp;
  logic              w_writes, w_isBranch, w_isJal, w_useImm, w_illegal, w_taken;
  logic              w_wbWe, w_extInRange, w_dbgInRange, w_trapSuppress;

  assign w_op   = r_ir[31:26];
  assign w_funct = r_ir[5:0];
  assign w_rs   = r_ir[21 +: AW];
  assign w_rt   = r_ir[16 +: AW];
  assign w_rd   = r_ir[11 +: AW];
  assign w_simm = {{(DATA_W-16){r_ir[15]}}, r_ir[15:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (instr_valid) w_nextState = DECODE;
      DECODE:  w_nextState = EXEC;
      EXEC:    w_nextState = WB;
      WB:      w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_aluOp    = ALU_ADD;
    w_writes   = 1'b0;
    w_dest     = w_rd;
    w_isBranch = 1'b0;
    w_isJal    = 1'b0;
    w_useImm   = 1'b0;
    w_illegal  = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_writes = 1'b1;
        case (w_funct)
          FN_ADD:  w_aluOp = ALU_ADD;
          FN_SUB:  w_aluOp = ALU_SUB;
          FN_AND:  w_aluOp = ALU_AND;
          FN_OR:   w_aluOp = ALU_OR;
          FN_XOR:  w_aluOp = ALU_XOR;
          FN_SLT:  w_aluOp = ALU_SLT;
          default: begin
            w_writes  = 1'b0;
            w_illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        w_writes = 1'b1;
        w_dest   = w_rt;
        w_useImm = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        w_aluOp    = ALU_SUB;
        w_isBranch = 1'b1;
      end
      OP_JAL: begin
        w_writes = 1'b1;
        w_dest   = LINK_IDX;
        w_isJal  = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // JAL reuses the adder to form the link address PC+4.
  assign w_srcA = w_isJal ? r_pc : r_a;
  assign w_srcB = w_isJal ? DATA_W'(4) : (w_useImm ? w_simm : r_b);

  always_comb begin
    w_aluRes = '0;
    case (w_aluOp)
      ALU_ADD: w_aluRes = w_srcA + w_srcB;
      ALU_SUB: w_aluRes = w_srcA - w_srcB;
      ALU_AND: w_aluRes = w_srcA & w_srcB;
      ALU_OR:  w_aluRes = w_srcA | w_srcB;
      ALU_XOR: w_aluRes = w_srcA ^ w_srcB;
      ALU_SLT: w_aluRes = {{(DATA_W-1){1'b0}}, ($signed(w_srcA) < $signed(w_srcB))};
      default: w_aluRes = '0;
    endcase
  end

  assign w_pcPlus4 = r_pc + DATA_W'(4);
  assign w_taken   = w_isBranch && ((w_op == OP_BEQ) ? (w_aluRes == '0) : (w_aluRes != '0));

  always_comb begin
    w_nextPcCalc = w_pcPlus4;
    if (w_taken)      w_nextPcCalc = w_pcPlus4 + (w_simm << 2);
    else if (w_isJal) w_nextPcCalc = {r_pc[DATA_W-1:28], r_ir[25:0], 2'b00};
  end

`ifdef MC_EXEC_OVF_TRAP_EN
  logic r_trap, w_ovfChk, w_ovf;
  assign w_ovfChk = (w_op == OP_ADDI) ||
                    ((w_op == OP_RTYPE) && ((w_funct == FN_ADD) || (w_funct == FN_SUB)));
  // Overflow when the operands' effective signs agree but the result's sign differs.
  assign w_ovf = (w_aluOp == ALU_SUB)
               ? ((w_srcA[DATA_W-1] != w_srcB[DATA_W-1]) && (w_aluRes[DATA_W-1] != w_srcA[DATA_W-1]))
               : ((w_srcA[DATA_W-1] == w_srcB[DATA_W-1]) && (w_aluRes[DATA_W-1] != w_srcA[DATA_W-1]));
  assign w_trapSuppress = r_trap;
  assign trap = r_trap;
`else
  assign w_trapSuppress = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir          <= '0;
      r_pc          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_aluOut      <= '0;
      r_zero        <= 1'b0;
      r_branchTaken <= 1'b0;
      r_nextPc      <= '0;
      r_illegal     <= 1'b0;
`ifdef MC_EXEC_OVF_TRAP_EN
      r_trap        <= 1'b0;
`endif
    end else begin
      if ((r_state == IDLE) && instr_valid) begin
        r_ir <= instr;
        r_pc <= pc_in;
      end
      if (r_state == DECODE) begin
        r_a <= w_rdA;
        r_b <= w_rdB;
      end
      if (r_state == EXEC) begin
        r_aluOut      <= w_aluRes;
        r_zero        <= (w_aluRes == '0);
        r_branchTaken <= w_taken;
        r_nextPc      <= w_nextPcCalc;
        r_illegal     <= w_illegal;
`ifdef MC_EXEC_OVF_TRAP_EN
        r_trap        <= w_ovfChk && w_ovf;
`endif
      end
    end
  end

  // A writeback to R0 is not a real write, so it never blocks an external write.
  assign w_wbWe       = (r_state == WB) && w_writes && !w_trapSuppress && (w_dest != '0);
  assign w_extInRange = ({1'b0, ext_addr} < NUM_REGS6);
  assign w_dbgInRange = ({1'b0, dbg_addr} < NUM_REGS6);
  assign ext_ack      = ext_we && w_extInRange && !(w_wbWe && (ext_addr[AW-1:0] == w_dest));

  mc_exec_regfile #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_rdAddrA(w_rs),
    .i_rdAddrB(w_rt),
    .i_dbgAddr(dbg_addr[AW-1:0]),
    .o_rdDataA(w_rdA),
    .o_rdDataB(w_rdB),
    .o_dbgData(w_dbgData),
    .i_weA    (w_wbWe),
    .i_waddrA (w_dest),
    .i_wdataA (r_aluOut),
    .i_weB    (ext_ack),
    .i_waddrB (ext_addr[AW-1:0]),
    .i_wdataB (ext_data)
  );

  assign instr_ready  = (r_state == IDLE);
  assign done         = (r_state == WB);
  assign dbg_data     = w_dbgInRange ? w_dbgData : '0;
  assign alu_out      = r_aluOut;
  assign zero         = r_zero;
  assign branch_taken = r_branchTaken;
  assign next_pc      = r_nextPc;
  assign illegal      = r_illegal;

endmodule

// File: tb/tb_mc_exec_core.sv
// Directed plus randomized bench for mc_exec_core against an instruction-level reference model.
// Covers the MC_EXEC_OVF_TRAP_EN build when that macro is defined.
module tb_mc_exec_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc_in = '0;
  logic        ext_we = 1'b0;
  logic [4:0]  ext_addr = '0;
  logic [31:0] ext_data = '0;
  logic        ext_ack;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
  logic        done;
  logic [31:0] alu_out;
  logic        zero;
  logic        branch_taken;
  logic [31:0] next_pc;
  logic        illegal;
`ifdef MC_EXEC_OVF_TRAP_EN
  logic        trap;
`endif

  mc_exec_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .pc_in       (pc_in),
    .ext_we      (ext_we),
    .ext_addr    (ext_addr),
    .ext_data    (ext_data),
    .ext_ack     (ext_ack),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .done        (done),
    .alu_out     (alu_out),
    .zero        (zero),
    .branch_taken(branch_taken),
    .next_pc     (next_pc),
`ifdef MC_EXEC_OVF_TRAP_EN
    .trap        (trap),
`endif
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        writes;
    logic [4:0]  dest;
    logic [31:0] res;
    logic        taken;
    logic [31:0] npc;
    logic        ill;
    logic        ovf;
    logic        trp;
  } expect_t;

  int          checkCount = 0;
  int          passCount = 0;
  int          failCount = 0;
  logic [31:0] mregs [32];
  logic [31:0] lastNextPc;
  logic        lastTaken;
  logic        lastTrap;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic readReg(input logic [4:0] a, output logic [31:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  task automatic checkRegs(input string tag);
    logic [31:0] d;
    for (int i = 0; i < 32; i++) begin
      readReg(5'(i), d);
      checkOutput($sformatf("%s.R%0d", tag, i), d, mregs[i]);
    end
  endtask

  // Instruction-level semantics computed directly from register values.
  function automatic expect_t modelExec(input logic [31:0] ins, input logic [31:0] pc);
    expect_t     e;
    logic [31:0] a, b, simm;
    longint      wide;
    a    = mregs[ins[25:21]];
    b    = mregs[ins[20:16]];
    simm = {{16{ins[15]}}, ins[15:0]};
    wide = 0;
    e.writes = 1'b0;
    e.dest   = ins[15:11];
    e.res    = '0;
    e.taken  = 1'b0;
    e.npc    = pc + 32'd4;
    e.ill    = 1'b0;
    e.ovf    = 1'b0;
    e.trp    = 1'b0;
    case (ins[31:26])
      6'h00: begin
        e.writes = 1'b1;
        case (ins[5:0])
          6'h20: begin e.res = a + b; wide = longint'($signed(a)) + longint'($signed(b)); e.ovf = (wide != longint'($signed(e.res))); end
          6'h22: begin e.res = a - b; wide = longint'($signed(a)) - longint'($signed(b)); e.ovf = (wide != longint'($signed(e.res))); end
          6'h24: e.res = a & b;
          6'h25: e.res = a | b;
          6'h26: e.res = a ^ b;
          6'h2A: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: begin e.writes = 1'b0; e.ill = 1'b1; end
        endcase
      end
      6'h08: begin
        e.writes = 1'b1;
        e.dest   = ins[20:16];
        e.res    = a + simm;
        wide     = longint'($signed(a)) + longint'($signed(simm));
        e.ovf    = (wide != longint'($signed(e.res)));
      end
      6'h04, 6'h05: begin
        e.res   = a - b;
        e.taken = (ins[31:26] == 6'h04) ? (a == b) : (a != b);
        if (e.taken) e.npc = pc + 32'd4 + (simm << 2);
      end
      6'h03: begin
        e.writes = 1'b1;
        e.dest   = 5'd31;
        e.res    = pc + 32'd4;
        e.npc    = {pc[31:28], ins[25:0], 2'b00};
      end
      default: e.ill = 1'b1;
    endcase
`ifdef MC_EXEC_OVF_TRAP_EN
    if (e.ovf) begin
      e.trp    = 1'b1;
      e.writes = 1'b0;
      e.npc    = pc + 32'd4;
    end
`endif
    return e;
  endfunction

  task automatic extWrite(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    ext_we = 1'b1;
    ext_addr = a;
    ext_data = d;
    #1;
    checkOutput($sformatf("extAck.R%0d", a), 32'(ext_ack), 32'd1);
    tick();
    ext_we = 1'b0;
    if (a != 5'd0) mregs[a] = d;
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                               input logic doExt, input logic [4:0] extA, input logic [31:0] extD);
    expect_t     e;
    int          lat;
    logic        gotDone;
    logic        expAck;
    logic [31:0] d;
    e = modelExec(ins, pc);
    @(negedge clk);
    instr = ins;
    pc_in = pc;
    instr_valid = 1'b1;
    #1;
    checkOutput({tag, ".ready"}, 32'(instr_ready), 32'd1);
    tick();
    instr = $urandom;
    pc_in = $urandom;
    lat = 0;
    gotDone = 1'b0;
    while (!gotDone && lat < 10) begin
      tick();
      lat++;
      gotDone = done;
      if (lat == 1) checkOutput({tag, ".busyNotReady"}, 32'(instr_ready), 32'd0);
    end
    instr_valid = 1'b0;
    checkOutput({tag, ".latency"}, 32'(lat), 32'd2);
    if (!gotDone) return;
    lastNextPc = next_pc;
    lastTaken  = branch_taken;
    lastTrap   = 1'b0;
    checkOutput({tag, ".illegal"}, 32'(illegal), 32'(e.ill));
    checkOutput({tag, ".nextPc"}, next_pc, e.npc);
    checkOutput({tag, ".taken"}, 32'(branch_taken), 32'(e.taken));
    if (!e.ill) begin
      checkOutput({tag, ".aluOut"}, alu_out, e.res);
      checkOutput({tag, ".zero"}, 32'(zero), 32'(e.res == 32'd0));
    end
`ifdef MC_EXEC_OVF_TRAP_EN
    lastTrap = trap;
    checkOutput({tag, ".trap"}, 32'(trap), 32'(e.trp));
`endif
    expAck = 1'b0;
    if (doExt) begin
      ext_we = 1'b1;
      ext_addr = extA;
      ext_data = extD;
      #1;
      expAck = !(e.writes && (e.dest != 5'd0) && (e.dest == extA));
      checkOutput({tag, ".wbExtAck"}, 32'(ext_ack), 32'(expAck));
    end
    tick();
    ext_we = 1'b0;
    if (e.writes && e.dest != 5'd0) mregs[e.dest] = e.res;
    if (doExt && expAck && extA != 5'd0) mregs[extA] = extD;
    checkOutput({tag, ".doneDrop"}, 32'(done), 32'd0);
    if (e.writes) begin
      readReg(e.dest, d);
      checkOutput({tag, ".dest"}, d, mregs[e.dest]);
    end
    if (doExt) begin
      readReg(extA, d);
      checkOutput({tag, ".extDest"}, d, mregs[extA]);
    end
  endtask

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  initial begin
    logic [31:0] d;
    logic [5:0]  fnTable [6];
    fnTable = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A};
    for (int i = 0; i < 32; i++) mregs[i] = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.ready", 32'(instr_ready), 32'd1);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.aluOut", alu_out, 32'd0);
    checkOutput("reset.zero", 32'(zero), 32'd0);
    checkOutput("reset.taken", 32'(branch_taken), 32'd0);
    checkOutput("reset.nextPc", next_pc, 32'd0);
    checkOutput("reset.illegal", 32'(illegal), 32'd0);
    rst_n = 1'b1;
    checkRegs("reset");

    extWrite(5'd1, 32'd5);
    extWrite(5'd2, 32'd3);
    applyStimulus("add", rType(5'd1, 5'd2, 5'd3, 6'h20), 32'h0000_0040, 1'b0, 5'd0, 32'd0);
    readReg(5'd3, d);
    checkOutput("add.R3const", d, 32'd8);
    checkOutput("add.nextPcConst", lastNextPc, 32'h0000_0044);
    applyStimulus("sub", rType(5'd2, 5'd1, 5'd4, 6'h22), 32'h0, 1'b0, 5'd0, 32'd0);
    readReg(5'd4, d);
    checkOutput("sub.R4const", d, 32'hFFFF_FFFE);
    applyStimulus("slt", rType(5'd4, 5'd1, 5'd5, 6'h2A), 32'h0, 1'b0, 5'd0, 32'd0);
    readReg(5'd5, d);
    checkOutput("slt.R5const", d, 32'd1);
    applyStimulus("addi", {6'h08, 5'd0, 5'd6, 16'hFFFF}, 32'h0, 1'b0, 5'd0, 32'd0);
    readReg(5'd6, d);
    checkOutput("addi.R6const", d, 32'hFFFF_FFFF);
    applyStimulus("beq", {6'h04, 5'd1, 5'd1, 16'd4}, 32'h0000_0100, 1'b0, 5'd0, 32'd0);
    checkOutput("beq.takenConst", 32'(lastTaken), 32'd1);
    checkOutput("beq.nextPcConst", lastNextPc, 32'h0000_0114);
    applyStimulus("bne", {6'h05, 5'd1, 5'd1, 16'd4}, 32'h0000_0100, 1'b0, 5'd0, 32'd0);
    checkOutput("bne.takenConst", 32'(lastTaken), 32'd0);
    checkOutput("bne.nextPcConst", lastNextPc, 32'h0000_0104);
    applyStimulus("jal", {6'h03, 26'h40}, 32'h0000_1000, 1'b0, 5'd0, 32'd0);
    readReg(5'd31, d);
    checkOutput("jal.R31const", d, 32'h0000_1004);
    checkOutput("jal.nextPcConst", lastNextPc, 32'h0000_0100);
    applyStimulus("illegalOp", {6'h3F, 26'h0}, 32'h0000_0200, 1'b0, 5'd0, 32'd0);
    applyStimulus("illegalFn", rType(5'd1, 5'd2, 5'd9, 6'h00), 32'h0000_0300, 1'b0, 5'd0, 32'd0);
    extWrite(5'd0, 32'hDEAD_BEEF);
    readReg(5'd0, d);
    checkOutput("extR0.stays0", d, 32'd0);
    applyStimulus("addExt7", rType(5'd1, 5'd2, 5'd3, 6'h20), 32'h0, 1'b1, 5'd7, 32'hA5A5_0007);
    readReg(5'd7, d);
    checkOutput("addExt7.R7const", d, 32'hA5A5_0007);
    applyStimulus("addExt3", rType(5'd1, 5'd2, 5'd3, 6'h20), 32'h0, 1'b1, 5'd3, 32'h0000_1234);
    readReg(5'd3, d);
    checkOutput("addExt3.R3const", d, 32'd8);

`ifdef MC_EXEC_OVF_TRAP_EN
    extWrite(5'd8, 32'h7FFF_FFFF);
    extWrite(5'd9, 32'd1);
    extWrite(5'd10, 32'h55);
    applyStimulus("ovfAdd", rType(5'd8, 5'd9, 5'd10, 6'h20), 32'h0000_0400, 1'b0, 5'd0, 32'd0);
    checkOutput("ovfAdd.trapConst", 32'(lastTrap), 32'd1);
    readReg(5'd10, d);
    checkOutput("ovfAdd.R10const", d, 32'h55);
`endif

    for (int i = 1; i < 32; i++) extWrite(5'(i), $urandom);
    for (int n = 0; n < 60; n++) begin
      int          k;
      logic [4:0]  rs, rt, rd, extA;
      logic [31:0] ins, pc;
      k  = int'($urandom_range(0, 10));
      rs = 5'($urandom_range(0, 31));
      rt = ($urandom_range(0, 1) == 0) ? rs : 5'($urandom_range(0, 31));
      rd = 5'($urandom_range(0, 31));
      pc = $urandom & 32'hFFFF_FFFC;
      case (k)
        6:  ins = {6'h08, rs, rt, 16'($urandom)};
        7:  ins = {6'h04, rs, rt, 16'($urandom)};
        8:  ins = {6'h05, rs, rt, 16'($urandom)};
        9:  ins = {6'h03, 26'($urandom)};
        10: ins = ($urandom_range(0, 1) == 0) ? {6'h3F, 26'($urandom)} : rType(rs, rt, rd, 6'h01);
        default: ins = rType(rs, rt, rd, fnTable[k]);
      endcase
      extA = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      applyStimulus($sformatf("rand%0d", n), ins, pc, ($urandom_range(0, 2) == 0), extA, $urandom);
    end
    checkRegs("final");

    @(negedge clk);
    instr = rType(5'd1, 5'd2, 5'd11, 6'h20);
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midReset.done", 32'(done), 32'd0);
    checkOutput("midReset.ready", 32'(instr_ready), 32'd1);
    checkOutput("midReset.aluOut", alu_out, 32'd0);
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("midReset.noDone", 32'(done), 32'd0);
    checkRegs("midReset");

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
